demux_4_1_buffered: RTL and testbench

Buffered 1-to-4 demultiplexer for the 12-bit datapath. It accepts one word per cycle from a single source with a valid/ready handshake and steers it, by a 2-bit select, into one of four independent per-destination FIFOs. Each FIFO drains through its own valid/ready port. The block sits where a single result bus fans out to register/consumer ports, and lets destinations stall independently without dropping words.

---
 rtl/demux_4_1_buffered.sv | 98 +++++++++
 tb/tb_demux_4_1_buffered.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/demux_4_1_buffered.sv
// Buffered 1-to-4 demultiplexer: a single valid/ready source is steered by
// in_select into one of four independent FIFOs. Each FIFO drains through its
// own valid/ready port, so destinations can stall without losing words.
// Outputs come straight from registered state; in_ready never depends on
// out_ready, so a full target refuses a word even while it is draining.
module demux_4_1_buffered #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
);

    localparam int NUM_DEST = 4;
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Per-destination storage and bookkeeping. Pointers wrap naturally
    // because DEPTH is a power of two; count tells full from empty.
    logic [WIDTH-1:0] mem    [NUM_DEST][DEPTH];
    logic [PTR_W-1:0] rd_ptr [NUM_DEST];
    logic [PTR_W-1:0] wr_ptr [NUM_DEST];
    logic [CNT_W-1:0] count  [NUM_DEST];

    logic [NUM_DEST-1:0] push;
    logic [NUM_DEST-1:0] pop;

    // Source may hand over a word whenever the selected FIFO is not full.
    assign in_ready = (count[in_select] != CNT_FULL);

    // Decode the accepted word into a one-hot push and form per-FIFO pops.
    always_comb begin
        // NOTE: every always_comb output gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        push = '0;
        for (int f = 0; f < NUM_DEST; f++) begin
            out_valid[f] = (count[f] != '0);
        end
        if (in_valid && in_ready) begin
            push[in_select] = 1'b1;
        end
        pop = out_valid & out_ready;
    end

    // Head word of each FIFO, read directly from the registered storage.
    assign out_data0 = mem[0][rd_ptr[0]];
    assign out_data1 = mem[1][rd_ptr[1]];
    assign out_data2 = mem[2][rd_ptr[2]];
    assign out_data3 = mem[3][rd_ptr[3]];

    // FIFO state update: write on push, advance read on pop, track count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int f = 0; f < NUM_DEST; f++) begin
                rd_ptr[f] <= '0;
                wr_ptr[f] <= '0;
                count[f]  <= '0;
                // NOTE: the storage itself is cleared here so every out_data
                // reads 0 after reset; this costs a reset on each entry.
                for (int e = 0; e < DEPTH; e++) begin
                    mem[f][e] <= '0;
                end
            end
        end else begin
            for (int f = 0; f < NUM_DEST; f++) begin
                // NOTE: sequential state uses non-blocking assignments so
                // every read in this block sees the pre-edge values.
                if (push[f]) begin
                    mem[f][wr_ptr[f]] <= in_data;
                    wr_ptr[f]         <= wr_ptr[f] + PTR_ONE;
                end
                if (pop[f]) begin
                    rd_ptr[f] <= rd_ptr[f] + PTR_ONE;
                end
                case ({push[f], pop[f]})
                    2'b10:   count[f] <= count[f] + CNT_ONE;
                    2'b01:   count[f] <= count[f] - CNT_ONE;
                    default: count[f] <= count[f];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_4_1_buffered.sv
// Self-checking bench for demux_4_1_buffered. A queue per destination models
// the expected contents; outputs are compared on the falling clock edge.
module tb_demux_4_1_buffered;

    localparam int WIDTH = 12;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    logic [WIDTH-1:0] od [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    demux_4_1_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference model: expected contents of each destination, oldest first.
    logic [WIDTH-1:0] q [4][$];
    bit               clean [4];   // no word written since reset -> data reads 0
    int               checks = 0;
    int               errors = 0;
    bit               last_accept;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            clean[i] = 1'b1;
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model over the edge.
    task automatic tick();
        bit         exp_ready;
        logic [3:0] exp_valid;
        bit         accept;
        logic [3:0] pops;
        @(negedge clk);
        exp_ready = (q[in_select].size() != DEPTH);
        for (int i = 0; i < 4; i++) exp_valid[i] = (q[i].size() != 0);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() != 0)
                check($sformatf("out_data%0d", i), 32'(od[i]), 32'(q[i][0]));
            else if (clean[i])
                check($sformatf("out_data%0d_zero", i), 32'(od[i]), 32'h0);
        end
        accept = rst && in_valid && exp_ready;
        pops   = rst ? (exp_valid & out_ready) : 4'b0000;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) if (pops[i]) void'(q[i].pop_front());
            if (accept) begin
                q[in_select].push_back(in_data);
                clean[in_select] = 1'b0;
            end
        end
        last_accept = accept;
        #1;
    endtask

    initial begin
        // Reset held for two edges with a valid word pending.
        rst = 1'b0; in_valid = 1'b1; in_select = 2'd0; in_data = 12'h5A5; out_ready = 4'b0000;
        @(posedge clk);
        model_reset();
        #1;
        tick();
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        tick();

        // Single route to destination 2, then drain it.
        in_valid = 1'b1; in_select = 2'd2; in_data = 12'hABC;
        tick();
        in_valid = 1'b0;
        tick();
        check("route_data2", 32'(out_data2), 32'hABC);
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        tick();

        // Fill destination 1 and hold the third word under backpressure.
        in_valid = 1'b1; in_select = 2'd1; in_data = 12'h111;
        tick();
        in_data = 12'h222;
        tick();
        in_data = 12'h333;
        tick();
        tick();
        out_ready = 4'b0010;
        tick();                 // pop 0x111, still full -> refused
        tick();                 // pop 0x222, 0x333 accepted
        check("fill_accept_333", 32'(last_accept), 32'd1);
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 4'b0000;

        // Streaming to destination 0 at one word per cycle.
        out_ready = 4'b0001; in_select = 2'd0;
        for (int w = 1; w <= 16; w++) begin
            in_valid = 1'b1; in_data = 12'(w);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 4'b0000;

        // Independence: full destination 3 must not block destination 0.
        in_valid = 1'b1; in_select = 2'd3; in_data = 12'h3A1;
        tick();
        in_data = 12'h3A2;
        tick();
        in_select = 2'd0; in_data = 12'h7FF;
        tick();
        in_valid = 1'b0;
        tick();
        check("indep_data0", 32'(out_data0), 32'h7FF);
        check("indep_data3", 32'(out_data3), 32'h3A1);
        in_valid = 1'b1; in_select = 2'd2; in_data = 12'h2B2;
        tick();

        // Mid-operation reset with words buffered and a push/pop pending.
        rst = 1'b0; in_select = 2'd1; in_data = 12'h999; out_ready = 4'b1111;
        tick();
        rst = 1'b1; in_valid = 1'b0; out_ready = 4'b0000;
        tick();
        in_valid = 1'b1; in_select = 2'd0; in_data = 12'h0C3;
        tick();
        in_valid = 1'b0;
        tick();
        check("after_reset_valid", 32'(out_valid), 32'h1);

        // Randomised traffic; a refused word is held until accepted.
        for (int c = 0; c < 400; c++) begin
            if (!(in_valid && !last_accept) || !rst) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_select = 2'($urandom_range(0, 3));
                in_data   = 12'($urandom);
            end
            out_ready = 4'($urandom);
            rst = ($urandom_range(0, 99) != 0);
            tick();
            rst = 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 4'b1111;
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
